// File: rtl/conv_tile_sequencer_pkg.sv
// Shared types and sizing for the convolution tile sequencer.
// Operand/result geometry is fixed by the 2x2 systolic array (4x4 tile, 3x3 filter).
package conv_tile_sequencer_pkg;

  localparam int DW                  = 8;
  localparam int N_PIX               = 16;
  localparam int N_FIL               = 9;
  localparam int N_OPERANDS          = N_PIX + N_FIL;
  localparam int N_RESULTS           = 4;
  localparam int COMPUTE_CYCLES_DEF  = 20;

  localparam int OP_CNT_W  = $clog2(N_OPERANDS);
  localparam int PIX_IDX_W = $clog2(N_PIX);
  localparam int FIL_IDX_W = $clog2(N_FIL);
  localparam int RES_CNT_W = $clog2(N_RESULTS);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_COMPUTE,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/conv_result_drain.sv
// Four-entry result buffer and valid/ready serializer for the array outputs.
// A capture strobe loads all results at once; done_o pulses on the final handshake.
module conv_result_drain
  import conv_tile_sequencer_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             capture_i,
  input  logic [N_RESULTS-1:0][DW-1:0]     res_i,
  input  logic                             m_ready_i,
  output logic [DW-1:0]                    m_data_o,
  output logic                             m_valid_o,
  output logic                             m_last_o,
  output logic                             done_o
);

  localparam logic [RES_CNT_W-1:0] R_LAST = RES_CNT_W'(N_RESULTS - 1);

  logic [N_RESULTS-1:0][DW-1:0] buf_q;
  logic [RES_CNT_W-1:0]         r_q;
  logic [RES_CNT_W-1:0]         r_d;
  logic [DW-1:0]                m_data_q;
  logic                         m_valid_q;
  logic                         m_last_q;
  logic                         hs;

  assign hs     = m_valid_q && m_ready_i;
  assign r_d    = r_q + 1'b1;
  assign done_o = hs && (r_q == R_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_q     <= '0;
      r_q       <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else if (capture_i) begin
      // first byte is presented straight from the array so DRAIN starts with valid data
      buf_q     <= res_i;
      r_q       <= '0;
      m_data_q  <= res_i[0];
      m_valid_q <= 1'b1;
      m_last_q  <= (R_LAST == '0);
    end else if (hs) begin
      if (r_q == R_LAST) begin
        r_q       <= '0;
        m_valid_q <= 1'b0;
        m_last_q  <= 1'b0;
      end else begin
        r_q      <= r_d;
        m_data_q <= buf_q[r_d];
        m_last_q <= (r_d == R_LAST);
      end
    end
  end

  assign m_data_o  = m_data_q;
  assign m_valid_o = m_valid_q;
  assign m_last_o  = m_last_q;

endmodule

// File: rtl/conv_tile_sequencer.sv
// Operand writer / result reader for the 2x2 systolic convolution array.
//   state      | meaning
//   ST_LOAD    | accept 16 pixel + 9 weight bytes, array held in reset
//   ST_COMPUTE | array released for COMPUTE_CYCLES cycles, results captured on the last one
//   ST_DRAIN   | serialize c11,c12,c21,c22 over valid/ready
module conv_tile_sequencer
  import conv_tile_sequencer_pkg::*;
#(
  parameter int COMPUTE_CYCLES = COMPUTE_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DW-1:0]         s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DW-1:0]         m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [N_PIX*DW-1:0]   pix_flat,
  output logic [N_FIL*DW-1:0]   fil_flat,
  output logic                  arr_rst,
  input  logic [DW-1:0]         c11,
  input  logic [DW-1:0]         c12,
  input  logic [DW-1:0]         c21,
  input  logic [DW-1:0]         c22,
  output logic                  busy
);

  localparam int CYC_W = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;
  localparam logic [CYC_W-1:0]    CYC_LAST = CYC_W'(COMPUTE_CYCLES - 1);
  localparam logic [OP_CNT_W-1:0] OP_LAST  = OP_CNT_W'(N_OPERANDS - 1);

  state_e                   state_q;
  logic [OP_CNT_W-1:0]      op_q;
  logic [CYC_W-1:0]         cyc_q;
  logic                     s_ready_q;
  logic                     arr_rst_q;
  logic                     busy_q;
  logic [N_PIX-1:0][DW-1:0] pix_q;
  logic [N_FIL-1:0][DW-1:0] fil_q;

  logic                     accept;
  logic                     capture;
  logic                     drain_done;
  logic [FIL_IDX_W-1:0]     fil_idx;

  assign accept  = (state_q == ST_LOAD) && s_valid && s_ready_q;
  assign capture = (state_q == ST_COMPUTE) && (cyc_q == CYC_LAST);
  assign fil_idx = FIL_IDX_W'(op_q - OP_CNT_W'(N_PIX));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_LOAD;
      op_q      <= '0;
      cyc_q     <= '0;
      s_ready_q <= 1'b1;
      arr_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      pix_q     <= '0;
      fil_q     <= '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (accept) begin
            if (op_q < OP_CNT_W'(N_PIX)) pix_q[op_q[PIX_IDX_W-1:0]] <= s_data;
            else                         fil_q[fil_idx]             <= s_data;
            if (op_q == OP_LAST) begin
              op_q      <= '0;
              cyc_q     <= '0;
              state_q   <= ST_COMPUTE;
              s_ready_q <= 1'b0;
              arr_rst_q <= 1'b0;
              busy_q    <= 1'b1;
            end else begin
              op_q <= op_q + 1'b1;
            end
          end
        end
        ST_COMPUTE: begin
          if (capture) begin
            cyc_q     <= '0;
            state_q   <= ST_DRAIN;
            arr_rst_q <= 1'b1;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            state_q   <= ST_LOAD;
            s_ready_q <= 1'b1;
            busy_q    <= 1'b0;
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  conv_result_drain u_drain (
    .clk       (clk),
    .rst       (rst),
    .capture_i (capture),
    .res_i     ({c22, c21, c12, c11}),
    .m_ready_i (m_ready),
    .m_data_o  (m_data),
    .m_valid_o (m_valid),
    .m_last_o  (m_last),
    .done_o    (drain_done)
  );

  assign s_ready  = s_ready_q;
  assign arr_rst  = arr_rst_q;
  assign busy     = busy_q;
  assign pix_flat = pix_q;
  assign fil_flat = fil_q;

endmodule

// File: tb/tb_conv_tile_sequencer.sv
// Bench for conv_tile_sequencer with a behavioural stand-in for the 2x2 systolic array.
// Directed and random tiles come from one vector table; reset-abort is a hand-written sequence.
module tb_conv_tile_sequencer;

  localparam int CC = 20;

  logic         clk;
  logic         rst;
  logic [7:0]   s_data;
  logic         s_valid;
  logic         s_ready;
  logic [7:0]   m_data;
  logic         m_valid;
  logic         m_ready;
  logic         m_last;
  logic [127:0] pix_flat;
  logic [71:0]  fil_flat;
  logic         arr_rst;
  logic [7:0]   c11, c12, c21, c22;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  conv_tile_sequencer dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .pix_flat(pix_flat), .fil_flat(fil_flat), .arr_rst(arr_rst),
    .c11(c11), .c12(c12), .c21(c21), .c22(c22), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // valid 3x3 convolution of a 4x4 tile, output (r,c), wrapped to 8 bits
  function automatic logic [7:0] ref_conv(input logic [15:0][7:0] p, input logic [8:0][7:0] f,
                                          input int r, input int c);
    int acc = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        acc += int'(p[(r + i) * 4 + c + j]) * int'(f[i * 3 + j]);
    return 8'(acc);
  endfunction

  // array stand-in: results only become correct on the last allowed compute cycle
  int arr_cnt = 0;
  always @(posedge clk) begin
    if (arr_rst) arr_cnt <= 0;
    else         arr_cnt <= arr_cnt + 1;
  end
  assign c11 = (arr_cnt >= CC - 1) ? ref_conv(pix_flat, fil_flat, 0, 0) : 8'hEE;
  assign c12 = (arr_cnt >= CC - 1) ? ref_conv(pix_flat, fil_flat, 0, 1) : 8'hEE;
  assign c21 = (arr_cnt >= CC - 1) ? ref_conv(pix_flat, fil_flat, 1, 0) : 8'hEE;
  assign c22 = (arr_cnt >= CC - 1) ? ref_conv(pix_flat, fil_flat, 1, 1) : 8'hEE;

  typedef struct {
    logic [15:0][7:0] pix;
    logic [8:0][7:0]  fil;
    bit               gaps;
    int               stall;
    bit               vdur;
    logic [3:0][7:0]  exp;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_tile(input vec_t v);
    int  n = 0;
    int  guard = 0;
    bit  ph = 1'b0;
    bit  acc;
    while (n < 25 && guard < 400) begin
      if (v.gaps && ph) s_valid = 1'b0;
      else begin
        s_valid = 1'b1;
        s_data  = (n < 16) ? v.pix[n] : v.fil[n - 16];
      end
      ph = ~ph;
      check("load_s_ready", s_ready, 1);
      check("load_busy", busy, 0);
      acc = s_valid && s_ready;
      @(negedge clk);
      guard++;
      if (acc) n++;
    end
    check("load_complete", n, 25);
    s_valid = v.vdur;
    s_data  = 8'h5A;
    m_ready = 1'b1;
    check("compute_s_ready", s_ready, 0);
    check("compute_busy", busy, 1);
    check("pix_flat", pix_flat, v.pix);
    check("fil_flat", fil_flat, v.fil);
  endtask

  task automatic finish_tile(input vec_t v);
    int cnt = 0;
    while (arr_rst == 1'b0 && cnt < 100) begin
      check("compute_no_m_valid", m_valid, 0);
      check("compute_pix_hold", pix_flat, v.pix);
      check("compute_fil_hold", fil_flat, v.fil);
      cnt++;
      @(negedge clk);
    end
    check("compute_len", cnt, CC);
    for (int r = 0; r < 4; r++) begin
      for (int s = 0; s < v.stall; s++) begin
        m_ready = 1'b0;
        check("drain_valid", m_valid, 1);
        check("drain_data", m_data, v.exp[r]);
        check("drain_last", m_last, (r == 3));
        @(negedge clk);
      end
      check("drain_valid", m_valid, 1);
      check("drain_data", m_data, v.exp[r]);
      check("drain_last", m_last, (r == 3));
      check("drain_s_ready", s_ready, 0);
      m_ready = 1'b1;
      @(negedge clk);
    end
    m_ready = 1'b0;
    check("post_m_valid", m_valid, 0);
    check("post_s_ready", s_ready, 1);
    check("post_busy", busy, 0);
    check("post_arr_rst", arr_rst, 1);
    check("post_pix_hold", pix_flat, v.pix);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 16; k++) begin
      vecs[0].pix[k] = 8'(k + 1);
      vecs[1].pix[k] = 8'd30;
      vecs[2].pix[k] = 8'(k + 1);
      vecs[3].pix[k] = 8'd2;
      vecs[4].pix[k] = 8'(k + 1);
    end
    for (int k = 0; k < 9; k++) begin
      vecs[0].fil[k] = 8'd1;
      vecs[1].fil[k] = 8'd1;
      vecs[2].fil[k] = 8'd1;
      vecs[3].fil[k] = 8'd3;
      vecs[4].fil[k] = 8'd1;
    end
    vecs[0].gaps = 0; vecs[0].stall = 0; vecs[0].vdur = 0; vecs[0].exp = {8'd99, 8'd90, 8'd63, 8'd54};
    vecs[1].gaps = 0; vecs[1].stall = 0; vecs[1].vdur = 0; vecs[1].exp = {8'd14, 8'd14, 8'd14, 8'd14};
    vecs[2].gaps = 1; vecs[2].stall = 3; vecs[2].vdur = 0; vecs[2].exp = {8'd99, 8'd90, 8'd63, 8'd54};
    vecs[3].gaps = 0; vecs[3].stall = 0; vecs[3].vdur = 0; vecs[3].exp = {8'd54, 8'd54, 8'd54, 8'd54};
    vecs[4].gaps = 0; vecs[4].stall = 1; vecs[4].vdur = 1; vecs[4].exp = {8'd99, 8'd90, 8'd63, 8'd54};
    for (int i = 5; i < NV; i++) begin
      for (int k = 0; k < 16; k++) vecs[i].pix[k] = 8'($urandom);
      for (int k = 0; k < 9; k++)  vecs[i].fil[k] = 8'($urandom);
      vecs[i].gaps  = bit'($urandom_range(0, 1));
      vecs[i].stall = int'($urandom_range(0, 3));
      vecs[i].vdur  = bit'($urandom_range(0, 1));
      for (int r = 0; r < 4; r++) vecs[i].exp[r] = ref_conv(vecs[i].pix, vecs[i].fil, r / 2, r % 2);
    end

    rst = 1'b0; s_valid = 1'b0; s_data = 8'h00; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    check("rst_arr_rst", arr_rst, 1);
    check("rst_busy", busy, 0);
    check("rst_pix_flat", pix_flat, 0);
    check("rst_fil_flat", fil_flat, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      load_tile(vecs[i]);
      finish_tile(vecs[i]);
    end

    // abort during compute cycle 5
    load_tile(vecs[0]);
    s_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_in_compute", arr_rst, 0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_arr_rst", arr_rst, 1);
    check("abort_s_ready", s_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_m_valid", m_valid, 0);
    check("abort_pix_flat", pix_flat, 0);
    check("abort_fil_flat", fil_flat, 0);
    rst = 1'b1;
    m_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      check("abort_no_m_valid", m_valid, 0);
      check("abort_arr_rst_hold", arr_rst, 1);
      @(negedge clk);
    end
    m_ready = 1'b0;

    for (int i = 5; i < NV; i++) begin
      load_tile(vecs[i]);
      finish_tile(vecs[i]);
    end
    s_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
